// File: rtl/fpu_pkg.sv
// Shared definitions for the add/subtract FPU stages: field widths, the exponent
// all-ones value and the bit positions of the result class and exception flags.
package fpu_pkg;

   localparam int FPU_NEXP = 8;
   localparam int FPU_NSIG = 23;
   localparam int FPU_W    = FPU_NEXP + FPU_NSIG + 1;

   localparam logic [FPU_NEXP-1:0] EXP_ONES = '1;

   localparam int CLS_W    = 3;
   localparam int CLS_ZERO = 0;
   localparam int CLS_INF  = 1;
   localparam int CLS_NAN  = 2;

   localparam int FLG_W    = 2;
   localparam int FLG_UNF  = 0;
   localparam int FLG_OVF  = 1;

endpackage

// File: rtl/fpu_classify.sv
// Combinational decoder from exponent/significand fields to a one-hot-or-zero
// {is_nan, is_inf, is_zero} class vector; the sign never affects the class.
module fpu_classify
   import fpu_pkg::*;
#(
   parameter int NEXP = FPU_NEXP,
   parameter int NSIG = FPU_NSIG
) (
   input  logic [NEXP-1:0]  exp_i,
   input  logic [NSIG-1:0]  sig_i,
   output logic [CLS_W-1:0] class_o
);

   logic expOnes;
   logic expZero;
   logic sigZero;

   always_comb begin
      expOnes = &exp_i;
      expZero = ~|exp_i;
      sigZero = ~|sig_i;
      class_o = '0;
      class_o[CLS_ZERO] = expZero & sigZero;
      class_o[CLS_INF]  = expOnes & sigZero;
      class_o[CLS_NAN]  = expOnes & ~sigZero;
   end

endmodule

// File: rtl/fpu_result_buffer.sv
// First-word-fall-through result FIFO with per-entry class/flags and sticky
// exception flags. Define FPU_FLAG_COUNT_EN to add saturating flag counters.
module fpu_result_buffer
   import fpu_pkg::*;
#(
   parameter int NEXP  = FPU_NEXP,
   parameter int NSIG  = FPU_NSIG,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NEXP+NSIG:0]           in_s,
   input  logic                         in_overflow,
   input  logic                         in_underflow,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NEXP+NSIG:0]           out_s,
   output logic [FLG_W-1:0]             out_flags,
   output logic [CLS_W-1:0]             out_class,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         sticky_ovf,
   output logic                         sticky_unf,
   input  logic                         flag_clr
`ifdef FPU_FLAG_COUNT_EN
   ,
   output logic [7:0]                   ovf_cnt,
   output logic [7:0]                   unf_cnt
`endif
);

   localparam int W  = NEXP + NSIG + 1;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [W-1:0]     data_q  [DEPTH];
   logic [FLG_W-1:0] flags_q [DEPTH];
   logic [CLS_W-1:0] class_q [DEPTH];

   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [CW-1:0] count_q, count_d;
   logic          stickyOvf_q, stickyOvf_d;
   logic          stickyUnf_q, stickyUnf_d;

   logic             push;
   logic             pop;
   logic [CLS_W-1:0] inClass;
   logic [FLG_W-1:0] inFlags;

   fpu_classify #(
      .NEXP (NEXP),
      .NSIG (NSIG)
   ) u_classify (
      .exp_i   (in_s[NEXP+NSIG-1:NSIG]),
      .sig_i   (in_s[NSIG-1:0]),
      .class_o (inClass)
   );

   // No bypass in either direction: readiness and validity depend only on the
   // registered occupancy, never on the other side's handshake this cycle.
   always_comb begin
      in_ready  = (count_q < FULL_C);
      out_valid = (count_q != '0);
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;

      inFlags          = '0;
      inFlags[FLG_OVF] = in_overflow;
      inFlags[FLG_UNF] = in_underflow;

      wrPtr_d = push ? wrPtr_q + PW'(1) : wrPtr_q;
      rdPtr_d = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
      count_d = count_q + CW'(push) - CW'(pop);

      stickyOvf_d = (stickyOvf_q & ~flag_clr) | (push & in_overflow);
      stickyUnf_d = (stickyUnf_q & ~flag_clr) | (push & in_underflow);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         stickyOvf_q <= 1'b0;
         stickyUnf_q <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         stickyOvf_q <= stickyOvf_d;
         stickyUnf_q <= stickyUnf_d;
      end
   end

   // Storage is deliberately left out of reset; the pointers define what is live.
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wrPtr_q]  <= in_s;
         flags_q[wrPtr_q] <= inFlags;
         class_q[wrPtr_q] <= inClass;
      end
   end

   assign out_s      = data_q[rdPtr_q];
   assign out_flags  = flags_q[rdPtr_q];
   assign out_class  = class_q[rdPtr_q];
   assign count      = count_q;
   assign sticky_ovf = stickyOvf_q;
   assign sticky_unf = stickyUnf_q;

`ifdef FPU_FLAG_COUNT_EN
   logic [7:0] ovfCnt_q, ovfCnt_d;
   logic [7:0] unfCnt_q, unfCnt_d;

   // Clear applies first so a flagged push in the clearing cycle lands on 1.
   always_comb begin
      ovfCnt_d = flag_clr ? 8'd0 : ovfCnt_q;
      unfCnt_d = flag_clr ? 8'd0 : unfCnt_q;
      if (push && in_overflow && ovfCnt_d != 8'hFF) begin
         ovfCnt_d = ovfCnt_d + 8'd1;
      end
      if (push && in_underflow && unfCnt_d != 8'hFF) begin
         unfCnt_d = unfCnt_d + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovfCnt_q <= 8'd0;
         unfCnt_q <= 8'd0;
      end else begin
         ovfCnt_q <= ovfCnt_d;
         unfCnt_q <= unfCnt_d;
      end
   end

   assign ovf_cnt = ovfCnt_q;
   assign unf_cnt = unfCnt_q;
`endif

endmodule
